fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit CPU, directly upstream of the instruction decoder. It owns the program counter and reads 16-bit instruction words from a synchronous, word-addressed instruction memory with one-cycle read latency. It presents one instruction at a time to the decoder over a valid/ready handshake. Execute-stage redirects for taken branches and jumps flush it and restart fetch at a new address.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_predecode.sv | 17 +
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants -- instruction width, opcode encodings, field
// positions and the fetch FSM state type.
package cpu_pkg;

  localparam int INSTR_W   = 16;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int JADDR_MSB = 11;
  localparam int JADDR_LSB = 0;

  localparam logic [3:0] OPC_ADD = 4'b0000;
  localparam logic [3:0] OPC_SUB = 4'b0001;
  localparam logic [3:0] OPC_AND = 4'b0010;
  localparam logic [3:0] OPC_OR  = 4'b0011;
  localparam logic [3:0] OPC_LD  = 4'b0100;
  localparam logic [3:0] OPC_ST  = 4'b0101;
  localparam logic [3:0] OPC_BEQ = 4'b0110;
  localparam logic [3:0] OPC_J   = 4'b0111;

  typedef enum logic [1:0] {
    S_REQ,
    S_RESP,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory port, execute redirect and decoder handshake
// of the fetch stage. master = fetch unit, slave = its environment.
interface fetch_unit_if #(
  parameter int ADDR_W = 12
);
  logic                         imem_req;
  logic [ADDR_W-1:0]            imem_addr;
  logic [cpu_pkg::INSTR_W-1:0]  imem_rdata;
  logic                         redirect_valid;
  logic [ADDR_W-1:0]            redirect_pc;
  logic                         if_valid;
  logic                         id_ready;
  logic [cpu_pkg::INSTR_W-1:0]  if_instr;
  logic [ADDR_W-1:0]            if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_predecode.sv
// fetch_predecode: combinational jump detector; extracts the absolute target of
// an unconditional jump so fetch can follow it without waiting for execute.
module fetch_predecode
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_is_jump,
  output logic [ADDR_W-1:0]  o_target
);

  assign o_is_jump = (i_instr[OPC_MSB:OPC_LSB] == OPC_J);
  // Jump field is zero-extended or truncated to the PC width.
  assign o_target  = ADDR_W'(i_instr[JADDR_MSB:JADDR_LSB]);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, keeps one instruction-memory read in flight at most and
// hands words to the decoder. Optional jump predecode under FETCH_PREDECODE_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_t        r_state;
  fetch_state_t        w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_seq_pc;
  logic [ADDR_W-1:0]   w_next_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic [ADDR_W-1:0]   r_if_pc;
  logic                w_req;

  assign w_seq_pc = r_pc + ADDR_W'(1);

`ifdef FETCH_PREDECODE_EN
  logic              w_is_jump;
  logic [ADDR_W-1:0] w_jump_target;

  fetch_predecode #(.ADDR_W(ADDR_W)) u_predecode (
    .i_instr   (bus.imem_rdata),
    .o_is_jump (w_is_jump),
    .o_target  (w_jump_target)
  );

  assign w_next_pc = w_is_jump ? w_jump_target : w_seq_pc;
`else
  assign w_next_pc = w_seq_pc;
`endif

  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    unique case (r_state)
      S_REQ: begin
        w_req        = 1'b1;
        w_next_state = S_RESP;
      end
      S_RESP: w_next_state = S_HOLD;
      // Handing over the held word and requesting the next one share a cycle.
      S_HOLD: begin
        if (bus.id_ready && !bus.redirect_valid) begin
          w_req        = 1'b1;
          w_next_state = S_RESP;
        end
      end
      default: w_next_state = S_REQ;
    endcase
    if (bus.redirect_valid) w_next_state = S_REQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_if_pc <= '0;
    end else begin
      r_state <= w_next_state;
      if (bus.redirect_valid) begin
        r_pc <= bus.redirect_pc;
      end else if (r_state == S_RESP) begin
        r_pc    <= w_next_pc;
        r_instr <= bus.imem_rdata;
        r_if_pc <= r_pc;
      end
    end
  end

  // Reset masks the strobe even though the reset state itself is S_REQ.
  assign bus.imem_req  = w_req & ~rst;
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = (r_state == S_HOLD) & ~bus.redirect_valid;
  assign bus.if_instr  = r_instr;
  assign bus.if_pc     = r_if_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit; two instances (RESET_PC 0x010 and
// 0xFFF) share clock and reset, each backed by a one-cycle-latency memory model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  fetch_unit_if #(.ADDR_W(12)) bus1 ();
  fetch_unit_if #(.ADDR_W(12)) bus2 ();

  fetch_unit #(.ADDR_W(12), .RESET_PC(12'h010)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  fetch_unit #(.ADDR_W(12), .RESET_PC(12'hFFF)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    if (a == 12'h005) return 16'h7123;
    return 16'h1000 + {4'h0, a};
  endfunction

  always @(posedge clk) begin
    bus1.imem_rdata <= bus1.imem_req ? mem_word(bus1.imem_addr) : 16'hDEAD;
    bus2.imem_rdata <= bus2.imem_req ? mem_word(bus2.imem_addr) : 16'hDEAD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    tick();
    tick();
    total++; if (bus1.if_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", bus1.if_valid); else passed++;
    total++; if (bus1.imem_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", bus1.imem_req); else passed++;
    total++; if (bus1.if_instr !== 16'h0000) $display("FAIL rst_instr: got %h want 0000", bus1.if_instr); else passed++;
    total++; if (bus1.if_pc !== 12'h000) $display("FAIL rst_pc: got %h want 000", bus1.if_pc); else passed++;
    total++; if (bus2.imem_req !== 1'b0) $display("FAIL rst_req2: got %0b want 0", bus2.imem_req); else passed++;
    bus1.id_ready = 1'b1;
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (bus1.imem_req !== 1'b1) $display("FAIL first_req: got %0b want 1", bus1.imem_req); else passed++;
    total++; if (bus1.imem_addr !== 12'h010) $display("FAIL first_addr: got %h want 010", bus1.imem_addr); else passed++;
    total++; if (bus2.imem_addr !== 12'hFFF) $display("FAIL first_addr2: got %h want fff", bus2.imem_addr); else passed++;
  endtask

  task automatic test_fetch_sequence();
    tick();
    total++; if (bus1.if_valid !== 1'b0) $display("FAIL resp_valid: got %0b want 0", bus1.if_valid); else passed++;
    total++; if (bus1.imem_req !== 1'b0) $display("FAIL resp_req: got %0b want 0", bus1.imem_req); else passed++;
    tick();
    total++; if (bus1.if_valid !== 1'b1) $display("FAIL seq0_valid: got %0b want 1", bus1.if_valid); else passed++;
    total++; if (bus1.if_instr !== 16'h1010) $display("FAIL seq0_instr: got %h want 1010", bus1.if_instr); else passed++;
    total++; if (bus1.if_pc !== 12'h010) $display("FAIL seq0_pc: got %h want 010", bus1.if_pc); else passed++;
    total++; if (bus1.imem_addr !== 12'h011 || bus1.imem_req !== 1'b1) $display("FAIL seq1_req: got %0b/%h want 1/011", bus1.imem_req, bus1.imem_addr); else passed++;
    total++; if (bus2.if_pc !== 12'hFFF || bus2.if_instr !== 16'h1FFF) $display("FAIL wrap0: got %h/%h want fff/1fff", bus2.if_pc, bus2.if_instr); else passed++;
    total++; if (bus2.imem_addr !== 12'h000) $display("FAIL wrap_addr: got %h want 000", bus2.imem_addr); else passed++;
    tick();
    tick();
    total++; if (bus1.if_instr !== 16'h1011 || bus1.if_pc !== 12'h011) $display("FAIL seq1: got %h/%h want 1011/011", bus1.if_instr, bus1.if_pc); else passed++;
    total++; if (bus2.if_pc !== 12'h000 || bus2.if_instr !== 16'h1000) $display("FAIL wrap1: got %h/%h want 000/1000", bus2.if_pc, bus2.if_instr); else passed++;
    tick();
    tick();
    total++; if (bus1.if_instr !== 16'h1012 || bus1.if_pc !== 12'h012 || bus1.if_valid !== 1'b1) $display("FAIL seq2: got %h/%h/%0b want 1012/012/1", bus1.if_instr, bus1.if_pc, bus1.if_valid); else passed++;
  endtask

  task automatic test_stall();
    bus1.id_ready = 1'b0;
    #1;
    total++; if (bus1.imem_req !== 1'b0) $display("FAIL stall_req0: got %0b want 0", bus1.imem_req); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus1.if_valid !== 1'b1 || bus1.if_instr !== 16'h1012 || bus1.if_pc !== 12'h012 || bus1.imem_req !== 1'b0)
        $display("FAIL stall_hold%0d: got v=%0b i=%h pc=%h req=%0b want 1/1012/012/0", i, bus1.if_valid, bus1.if_instr, bus1.if_pc, bus1.imem_req);
      else passed++;
    end
    bus1.id_ready = 1'b1;
    #1;
    total++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 12'h013) $display("FAIL stall_release: got %0b/%h want 1/013", bus1.imem_req, bus1.imem_addr); else passed++;
    tick();
    tick();
    total++; if (bus1.if_instr !== 16'h1013 || bus1.if_pc !== 12'h013) $display("FAIL stall_next: got %h/%h want 1013/013", bus1.if_instr, bus1.if_pc); else passed++;
  endtask

  task automatic test_redirect_resp();
    tick();
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 12'h200;
    #1;
    total++; if (bus1.if_valid !== 1'b0 || bus1.imem_req !== 1'b0) $display("FAIL rdr_resp_cycle: got %0b/%0b want 0/0", bus1.if_valid, bus1.imem_req); else passed++;
    tick();
    bus1.redirect_valid = 1'b0;
    #1;
    total++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 12'h200) $display("FAIL rdr_resp_req: got %0b/%h want 1/200", bus1.imem_req, bus1.imem_addr); else passed++;
    total++; if (bus1.if_valid !== 1'b0) $display("FAIL rdr_resp_stale: got %0b want 0", bus1.if_valid); else passed++;
    tick();
    total++; if (bus1.if_valid !== 1'b0) $display("FAIL rdr_resp_wait: got %0b want 0", bus1.if_valid); else passed++;
    tick();
    total++; if (bus1.if_valid !== 1'b1 || bus1.if_pc !== 12'h200 || bus1.if_instr !== 16'h1200)
      $display("FAIL rdr_resp_deliver: got %0b/%h/%h want 1/200/1200", bus1.if_valid, bus1.if_pc, bus1.if_instr);
    else passed++;
  endtask

  task automatic test_redirect_hold();
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 12'h200;
    #1;
    total++; if (bus1.if_valid !== 1'b0) $display("FAIL rdr_hold_valid: got %0b want 0", bus1.if_valid); else passed++;
    total++; if (bus1.imem_req !== 1'b0) $display("FAIL rdr_hold_req: got %0b want 0", bus1.imem_req); else passed++;
    tick();
    bus1.redirect_valid = 1'b0;
    #1;
    total++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 12'h200) $display("FAIL rdr_hold_next: got %0b/%h want 1/200", bus1.imem_req, bus1.imem_addr); else passed++;
    tick();
    tick();
    total++; if (bus1.if_valid !== 1'b1 || bus1.if_pc !== 12'h200 || bus1.if_instr !== 16'h1200)
      $display("FAIL rdr_hold_deliver: got %0b/%h/%h want 1/200/1200", bus1.if_valid, bus1.if_pc, bus1.if_instr);
    else passed++;
  endtask

  task automatic test_predecode();
    logic [11:0] exp_next;
`ifdef FETCH_PREDECODE_EN
    exp_next = 12'h123;
`else
    exp_next = 12'h006;
`endif
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 12'h005;
    tick();
    bus1.redirect_valid = 1'b0;
    #1;
    total++; if (bus1.imem_addr !== 12'h005) $display("FAIL jmp_fetch: got %h want 005", bus1.imem_addr); else passed++;
    tick();
    tick();
    total++; if (bus1.if_instr !== 16'h7123 || bus1.if_pc !== 12'h005) $display("FAIL jmp_deliver: got %h/%h want 7123/005", bus1.if_instr, bus1.if_pc); else passed++;
    total++; if (bus1.imem_addr !== exp_next) $display("FAIL jmp_next: got %h want %h", bus1.imem_addr, exp_next); else passed++;
  endtask

  task automatic test_wrap_redirect();
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 12'hFFF;
    tick();
    bus1.redirect_valid = 1'b0;
    tick();
    tick();
    total++; if (bus1.if_pc !== 12'hFFF || bus1.imem_addr !== 12'h000) $display("FAIL wrap_rdr: got %h/%h want fff/000", bus1.if_pc, bus1.imem_addr); else passed++;
    tick();
    tick();
    total++; if (bus1.if_pc !== 12'h000 || bus1.if_instr !== 16'h1000) $display("FAIL wrap_rdr_next: got %h/%h want 000/1000", bus1.if_pc, bus1.if_instr); else passed++;
  endtask

  task automatic test_reset_midop();
    tick();
    #2 rst = 1'b1;
    #1;
    total++; if (bus1.if_valid !== 1'b0 || bus1.imem_req !== 1'b0) $display("FAIL arst_ctrl: got %0b/%0b want 0/0", bus1.if_valid, bus1.imem_req); else passed++;
    total++; if (bus1.if_instr !== 16'h0000 || bus1.if_pc !== 12'h000) $display("FAIL arst_data: got %h/%h want 0000/000", bus1.if_instr, bus1.if_pc); else passed++;
    tick();
    total++; if (bus1.imem_req !== 1'b0) $display("FAIL arst_hold_req: got %0b want 0", bus1.imem_req); else passed++;
    tick();
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 12'h010) $display("FAIL arst_restart: got %0b/%h want 1/010", bus1.imem_req, bus1.imem_addr); else passed++;
    tick();
    tick();
    total++; if (bus1.if_valid !== 1'b1 || bus1.if_pc !== 12'h010 || bus1.if_instr !== 16'h1010)
      $display("FAIL arst_deliver: got %0b/%h/%h want 1/010/1010", bus1.if_valid, bus1.if_pc, bus1.if_instr);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus1.id_ready       = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = 12'h000;
    bus2.id_ready       = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 12'h000;
    test_reset();
    test_fetch_sequence();
    test_stall();
    test_redirect_resp();
    test_redirect_hold();
    test_predecode();
    test_wrap_redirect();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
